store_port_responder: RTL and testbench
=======================================

Name: store_port_responder

Overview:
- Responder side of the D$ store request port: accepts fire-and-forget write requests (req/gnt, no response) from the LSU store path.
- Holds accepted stores in a small coalescing write buffer. Stores to the same 8-byte word merge by byte-enable.
- Drains entries in order to the memory-side write interface using a req/gnt handshake.
- Sits between the store path and the memory arbiter; exposes an empty flag for fence/AMO gating.

Parameters:
- DEPTH, 4, number of write-buffer entries (power of two, ≥2).
- IDX_W, 12, request index width (ariane_pkg::DCACHE_INDEX_WIDTH).
- TAG_W, 44, request tag width (ariane_pkg::DCACHE_TAG_WIDTH).
- XLEN, 64, data width; word offset is 3 bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  store request valid (data_req)
- we_i  in  1  write enable; must be 1 whenever req_i=1
- index_i  in  IDX_W  address index (low bits)
- tag_i  in  TAG_W  address tag, valid in the same cycle as req_i
- wdata_i  in  XLEN  write data, byte lanes aligned to address[2:0]
- be_i  in  XLEN/8  byte enables; authoritative for which bytes are written
- size_i  in  2  access size; informational only
- gnt_o  out  1  request accepted this cycle
- mem_req_o  out  1  head entry valid toward memory
- mem_addr_o  out  TAG_W+IDX_W  word-aligned address, with bits [2:0]=0
- mem_wdata_o  out  XLEN  head entry data
- mem_be_o  out  XLEN/8  head entry byte enables
- mem_gnt_i  in  1  memory accepted head entry
- empty_o  out  1  no valid entries
- full_o  out  1  count==DEPTH

Behaviour:
- Address: addr = {tag_i, index_i}; word = addr[AW-1:3].
- Reset values: gnt_o=0, mem_req_o=0, mem_addr_o/mem_wdata_o/mem_be_o=0, empty_o=1, full_o=0. All entries invalid; read pointer, write pointer and count are 0.
- Reset asserted mid-operation discards all buffered stores; no memory request follows release until a new store is accepted.
- Entry fields: valid, word, data, be.
- Head lock: the head entry, at the read pointer, is locked whenever mem_req_o=1 and never changes while locked.
- Only non-head valid entries are merge candidates.
- Merge hit: req_i && we_i && a non-head valid entry has word equal to the request word.
  - Invariant: at most one unlocked entry per word, so at most one hit.
  - Verification checks this with a one-hot assertion.
- gnt_o (combinational) = req_i && we_i && (merge_hit || count<DEPTH).
  - A pop in the same cycle does not free space for a push; gnt_o never depends on mem_gnt_i.
- On grant with merge hit: for each byte b with be_i[b]=1, entry.data[b]=wdata_i[b] and entry.be[b]=1. Count and pointers are unchanged.
- On grant without hit: write the entry at the write pointer. The write pointer increments modulo DEPTH and the count increments.
  - If the head holds the same word, a new entry is allocated; the head is never merged into.
- Drain:
  - mem_req_o = head.valid, registered state only.
  - On mem_req_o && mem_gnt_i: invalidate the head, increment the read pointer modulo DEPTH, decrement the count.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Simultaneous merge and pop: the pop affects the head only; the merge targets another entry.
- Latency: a store granted in cycle N is visible on mem_req_o no earlier than cycle N+1. A merged store leaves with its host entry.
- Ordering: entries drain strictly in allocation order.
- Pointer wrap-around follows naturally from log2(DEPTH)-bit pointers. The count is log2(DEPTH)+1 bits.
- empty_o = (count==0); full_o = (count==DEPTH), both from registers.
- Assertions:
  - req_i → we_i.
  - No pop when empty.
  - Count never exceeds DEPTH.
  - mem_addr_o, mem_wdata_o and mem_be_o stable while mem_req_o && !mem_gnt_i.

Decomposition:
- Shared package (ariane_pkg):
  - wbuf_entry_t struct: valid, word, data, be.
  - WBUF_DEPTH constant.
  - Helper function be_merge(old_data, old_be, new_data, new_be) returning merged data and be.
- Natural sub-module: wbuf_match, a combinational CAM over the entries that produces the one-hot merge-hit vector, excluding the head.
- The FIFO control and registers stay in the top module.

Test Plan:
- Single store, addr=0x8000_0010, data=0x11223344_55667788, be=0xFF, mem_gnt_i=1 → gnt_o=1 in cycle 0; mem_req_o=1 in cycle 1 with mem_addr_o=0x8000_0010, mem_be_o=0xFF; empty_o=1 in cycle 2.
- mem_gnt_i=0. Store 0x1000 be=0x0F data=0xAAAA_AAAA, then 0x2000 be=0xFF, then 0x1004 be=0xF0 data=0xBBBB_BBBB_0000_0000:
  - Two entries allocated.
  - The third store allocates a new entry because the 0x1000 entry is the head, which is not mergeable.
  - Count=3.
- Same as the previous scenario, but the third store targets 0x2004 be=0xF0 → merges into entry 1; count stays 2; entry 1 be=0xFF with upper data from the merge.
- Fill DEPTH=4 with distinct words, mem_gnt_i=0 → full_o=1. A 5th distinct store gets gnt_o=0 even with mem_gnt_i=1 in that cycle. It is granted the next cycle after the pop.
- Push 10 stores with mem_gnt_i toggling 1,0,1,… → pointers wrap twice; memory sees all 10 in order with correct data; no entry lost or duplicated.
- 3 entries buffered, assert rst_ni=0 mid-drain → all outputs return to reset values immediately; after release, mem_req_o stays 0 until a new store is granted.

Source files
------------

// File: rtl/store_port_responder_pkg.sv
// rtl/store_port_responder_pkg.sv - shared types, sizes and byte-merge helper for the store write buffer
package store_port_responder_pkg;

    localparam int unsigned WBUF_DEPTH         = 4;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;
    localparam int unsigned WBUF_XLEN          = 64;
    localparam int unsigned WBUF_BE_W          = WBUF_XLEN / 8;
    localparam int unsigned WBUF_ADDR_W        = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
    localparam int unsigned WBUF_WORD_W        = WBUF_ADDR_W - 3;

    typedef logic [WBUF_WORD_W-1:0] word_t;

    typedef struct packed {
        logic                 valid;
        word_t                word;
        logic [WBUF_XLEN-1:0] data;
        logic [WBUF_BE_W-1:0] be;
    } wbuf_entry_t;

    typedef struct packed {
        logic [WBUF_XLEN-1:0] data;
        logic [WBUF_BE_W-1:0] be;
    } be_merge_t;

    // Newer bytes win; the byte-enable set only ever grows while an entry is buffered.
    function automatic be_merge_t be_merge(input logic [WBUF_XLEN-1:0] old_data,
                                           input logic [WBUF_BE_W-1:0] old_be,
                                           input logic [WBUF_XLEN-1:0] new_data,
                                           input logic [WBUF_BE_W-1:0] new_be);
        be_merge_t r;
        r.data = old_data;
        r.be   = old_be | new_be;
        for (int b = 0; b < int'(WBUF_BE_W); b++) begin
            if (new_be[b]) begin
                r.data[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/store_port_responder_if.sv
// rtl/store_port_responder_if.sv - store request port and memory-side write port bundle
interface store_port_responder_if
    import store_port_responder_pkg::*;
#(
    parameter int unsigned IDX_W = DCACHE_INDEX_WIDTH,
    parameter int unsigned TAG_W = DCACHE_TAG_WIDTH,
    parameter int unsigned XLEN  = WBUF_XLEN
);
    logic                   req;
    logic                   we;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic [XLEN-1:0]        wdata;
    logic [XLEN/8-1:0]      be;
    logic [1:0]             size;
    logic                   gnt;

    logic                   mem_req;
    logic [TAG_W+IDX_W-1:0] mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [XLEN/8-1:0]      mem_be;
    logic                   mem_gnt;

    modport master (
        output req, we, index, tag, wdata, be, size, mem_gnt,
        input  gnt, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req, we, index, tag, wdata, be, size, mem_gnt,
        output gnt, mem_req, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_port_responder_wbuf_match.sv
// rtl/store_port_responder_wbuf_match.sv - word-address CAM over the write buffer, head excluded
module store_port_responder_wbuf_match
    import store_port_responder_pkg::*;
#(
    parameter  int unsigned DEPTH = WBUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  word_t            word_i [DEPTH],
    input  logic [PTR_W-1:0] head_i,
    input  logic             req_i,
    input  word_t            req_word_i,
    output logic [DEPTH-1:0] hit_o
);

    // The head may be on the memory bus, so it is never a merge target.
    always_comb begin
        hit_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            hit_o[i] = req_i && valid_i[i] && (PTR_W'(i) != head_i) && (word_i[i] == req_word_i);
        end
    end

endmodule

// File: rtl/store_port_responder.sv
// rtl/store_port_responder.sv - coalescing store write buffer between the LSU store port and memory
module store_port_responder
    import store_port_responder_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH,
    parameter int unsigned IDX_W = DCACHE_INDEX_WIDTH,
    parameter int unsigned TAG_W = DCACHE_TAG_WIDTH,
    parameter int unsigned XLEN  = WBUF_XLEN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    store_port_responder_if.slave  bus,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam int unsigned      BE_W      = XLEN / 8;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    wbuf_entry_t       entries_q [DEPTH];
    wbuf_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W:0]    count_q, count_d;

    word_t             req_word;
    logic [DEPTH-1:0]  valid_vec;
    word_t             word_vec [DEPTH];
    logic [DEPTH-1:0]  hit;
    logic              merge_hit;
    logic              pop;
    logic              alloc;
    wbuf_entry_t       head;
    be_merge_t         merged;
    logic              unused_ok;

    assign req_word  = {bus.tag, bus.index[IDX_W-1:3]};
    assign unused_ok = ^{bus.size, bus.index[2:0]};

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_vec[i] = entries_q[i].valid;
            word_vec[i]  = entries_q[i].word;
        end
    end

    store_port_responder_wbuf_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .valid_i    (valid_vec),
        .word_i     (word_vec),
        .head_i     (rptr_q),
        .req_i      (bus.req && bus.we),
        .req_word_i (req_word),
        .hit_o      (hit)
    );

    assign merge_hit = |hit;
    assign head      = entries_q[rptr_q];
    assign pop       = head.valid && bus.mem_gnt;

    // Space is judged on registered count only, so a same-cycle pop never admits a push.
    assign bus.gnt   = bus.req && bus.we && (merge_hit || (count_q < DEPTH_CNT));
    assign alloc     = bus.gnt && !merge_hit;

    always_comb begin
        entries_d = entries_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        merged    = '0;

        if (pop) begin
            entries_d[rptr_q].valid = 1'b0;
            rptr_d                  = rptr_q + 1'b1;
        end

        if (bus.gnt) begin
            if (merge_hit) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (hit[i]) begin
                        merged            = be_merge(entries_q[i].data, entries_q[i].be,
                                                     bus.wdata, bus.be);
                        entries_d[i].data = merged.data;
                        entries_d[i].be   = merged.be;
                    end
                end
            end else begin
                entries_d[wptr_q] = '{valid: 1'b1, word: req_word, data: bus.wdata, be: bus.be};
                wptr_d            = wptr_q + 1'b1;
            end
        end

        count_d = count_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
        end
    end

    // Outputs are forced to zero when idle so the bus shows no stale entry contents.
    assign bus.mem_req   = head.valid;
    assign bus.mem_addr  = head.valid ? {head.word, 3'b000} : '0;
    assign bus.mem_wdata = head.valid ? head.data : '0;
    assign bus.mem_be    = head.valid ? head.be[BE_W-1:0] : '0;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);

    a_req_implies_we: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.req |-> bus.we);

    a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(hit));

    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && (count_q == '0)));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DEPTH_CNT);

    a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.mem_req && !bus.mem_gnt) |=> (bus.mem_req && $stable(bus.mem_addr)
                                          && $stable(bus.mem_wdata) && $stable(bus.mem_be)));

endmodule

// File: tb/tb_store_port_responder.sv
// tb/tb_store_port_responder.sv - scoreboard bench for the coalescing store write buffer
module tb_store_port_responder;

    localparam int DEPTH = 4;

    typedef struct {
        logic [52:0] word;
        logic [63:0] data;
        logic [7:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic empty;
    logic full;

    ent_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   writes_seen;
    bit   toggle_gnt;
    logic dut_gnt_seen;

    always #5 clk = ~clk;

    store_port_responder_if bus ();

    store_port_responder dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .empty_o (empty),
        .full_o  (full)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] bmask(input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic step();
        logic [52:0] rw;
        bit          hit;
        int          hi;
        bit          exp_gnt;
        bit          pop_now;
        ent_t        e;
        @(negedge clk);
        rw  = {bus.tag, bus.index[11:3]};
        hit = 0;
        hi  = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i].word == rw) begin
                hit = 1;
                hi  = i;
            end
        end
        exp_gnt = bus.req && (hit || q.size() < DEPTH);
        check("gnt", bus.gnt, exp_gnt);
        if (q.size() > 0) begin
            check("mem_req", bus.mem_req, 1);
            check("mem_addr", bus.mem_addr, {q[0].word, 3'b000});
            check("mem_be", bus.mem_be, q[0].be);
            check("mem_wdata", bus.mem_wdata & bmask(bus.mem_be), q[0].data & bmask(q[0].be));
        end else begin
            check("mem_req", bus.mem_req, 0);
            check("mem_addr", bus.mem_addr, 0);
            check("mem_be", bus.mem_be, 0);
            check("mem_wdata", bus.mem_wdata, 0);
        end
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == DEPTH);
        dut_gnt_seen = bus.gnt;
        if (bus.mem_req && bus.mem_gnt) writes_seen++;
        pop_now = (q.size() > 0) && bus.mem_gnt;
        if (exp_gnt) begin
            if (hit) begin
                for (int b = 0; b < 8; b++) begin
                    if (bus.be[b]) begin
                        q[hi].data[b*8 +: 8] = bus.wdata[b*8 +: 8];
                        q[hi].be[b]          = 1'b1;
                    end
                end
            end else begin
                e.word = rw;
                e.data = bus.wdata;
                e.be   = bus.be;
                q.push_back(e);
            end
        end
        if (pop_now) void'(q.pop_front());
        @(posedge clk);
        #1;
        if (toggle_gnt) bus.mem_gnt = ~bus.mem_gnt;
    endtask

    task automatic send(input logic [55:0] addr, input logic [63:0] data, input logic [7:0] be,
                        output int tries);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.tag   = addr[55:12];
        bus.index = addr[11:0];
        bus.wdata = data;
        bus.be    = be;
        bus.size  = 2'd3;
        tries     = 0;
        dut_gnt_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            tries++;
            if (dut_gnt_seen) break;
        end
        if (!dut_gnt_seen) check("send_timeout", 0, 1);
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic drain();
        bus.mem_gnt = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) step();
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        step();
    endtask

    initial begin
        int t;
        rst_n       = 1'b0;
        toggle_gnt  = 0;
        bus.req     = 1'b0;
        bus.we      = 1'b0;
        bus.tag     = '0;
        bus.index   = '0;
        bus.wdata   = '0;
        bus.be      = '0;
        bus.size    = '0;
        bus.mem_gnt = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step();

        // single store with immediate drain
        writes_seen = 0;
        bus.mem_gnt = 1'b1;
        send(56'h0000_0080_0000_10, 64'h1122_3344_5566_7788, 8'hFF, t);
        check("s1_tries", t, 1);
        repeat (2) step();
        check("s1_writes", writes_seen, 1);

        // same word as the head allocates a new entry
        writes_seen = 0;
        bus.mem_gnt = 1'b0;
        send(56'h1000, 64'h0000_0000_AAAA_AAAA, 8'h0F, t);
        send(56'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, t);
        send(56'h1004, 64'hBBBB_BBBB_0000_0000, 8'hF0, t);
        check("s2_not_empty", empty, 0);
        drain();
        check("s2_writes", writes_seen, 3);

        // non-head entry absorbs the upper half
        writes_seen = 0;
        bus.mem_gnt = 1'b0;
        send(56'h1000, 64'h0000_0000_AAAA_AAAA, 8'h0F, t);
        send(56'h2000, 64'h0000_0000_89AB_CDEF, 8'h0F, t);
        send(56'h2004, 64'hCCCC_CCCC_0000_0000, 8'hF0, t);
        drain();
        check("s3_writes", writes_seen, 2);

        // full buffer refuses a distinct store even while popping
        writes_seen = 0;
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(56'h3000 + 56'(i * 8), {32'h0, 32'(i)}, 8'hFF, t);
        step();
        bus.mem_gnt = 1'b1;
        send(56'h3020, 64'h5555_6666_7777_8888, 8'hFF, t);
        check("s4_tries", t, 2);
        drain();
        check("s4_writes", writes_seen, 5);

        // ten stores with alternating memory grant, pointers wrap
        writes_seen = 0;
        bus.mem_gnt = 1'b1;
        toggle_gnt  = 1;
        for (int i = 0; i < 10; i++)
            send(56'h4000 + 56'(i * 8), {$urandom, $urandom}, 8'(1 << (i % 8)) | 8'h01, t);
        toggle_gnt = 0;
        drain();
        check("s5_writes", writes_seen, 10);

        // reset in the middle of draining
        writes_seen = 0;
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) send(56'h5000 + 56'(i * 8), 64'hDEAD_0000 + 64'(i), 8'hFF, t);
        bus.mem_gnt = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("r_mem_req", bus.mem_req, 0);
        check("r_mem_addr", bus.mem_addr, 0);
        check("r_mem_be", bus.mem_be, 0);
        check("r_empty", empty, 1);
        check("r_full", full, 0);
        check("r_gnt", bus.gnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();
        send(56'h6000, 64'h0F0F_0F0F_F0F0_F0F0, 8'h3C, t);
        drain();
        check("r_writes", writes_seen, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
